id_char_gen: RTL and testbench

//  Transmit side of the character-stream interface consumed by id_fsm: emits one

---
 rtl/id_char_if.sv | 27 ++
 rtl/id_char_gen.sv | 124 ++++++++++++
 tb/tb_id_char_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/id_char_if.sv
// Character-stream bundle between the identifier generator and its consumer.
// It carries the request fields, the valid/ready character stream and the status pulses.
interface id_char_if #(
  parameter int LW = 4
);
  logic          start;
  logic [4:0]    let_start;
  logic [LW-1:0] let_len;
  logic [3:0]    dig_start;
  logic [LW-1:0] dig_len;
  logic [7:0]    char;
  logic          char_valid;
  logic          char_ready;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, let_start, let_len, dig_start, dig_len, char_ready,
    output char, char_valid, busy, done, err
  );

  modport slave (
    output start, let_start, let_len, dig_start, dig_len, char_ready,
    input  char, char_valid, busy, done, err
  );
endinterface

// File: rtl/id_char_gen.sv
// Emits one ASCII identifier per request: a run of letters, then a run of digits,
// one character per valid/ready transfer. Letters wrap z->a and digits wrap 9->0.
module id_char_gen #(
  parameter int         LW        = 4,
  parameter logic [7:0] IDLE_CHAR = 8'h00
) (
  input logic      clk,
  input logic      rst_n,
  id_char_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_LETTER, S_DIGIT, S_DONE} state_t;

  localparam logic [7:0] ASCII_A = 8'h61;
  localparam logic [7:0] ASCII_0 = 8'h30;

  state_t        state_q;
  logic [4:0]    let_idx_q, let_idx_d;
  logic [3:0]    dig_val_q, dig_val_d;
  logic [LW-1:0] let_rem_q, dig_rem_q;
  logic [7:0]    char_q;
  logic          valid_q, busy_q, done_q, err_q;
  logic          accept, req_bad;

  function automatic logic [7:0] let_char(input logic [4:0] idx);
    return ASCII_A + {3'b000, idx};
  endfunction

  function automatic logic [7:0] dig_char(input logic [3:0] val);
    return ASCII_0 + {4'b0000, val};
  endfunction

  assign accept    = valid_q && bus.char_ready;
  assign let_idx_d = (let_idx_q == 5'd25) ? 5'd0 : let_idx_q + 5'd1;
  assign dig_val_d = (dig_val_q == 4'd9)  ? 4'd0 : dig_val_q + 4'd1;
  assign req_bad   = (bus.let_len == '0) || (bus.let_start > 5'd25) || (bus.dig_start > 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      let_idx_q <= '0;
      dig_val_q <= '0;
      let_rem_q <= '0;
      dig_rem_q <= '0;
      char_q    <= IDLE_CHAR;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (req_bad) begin
              err_q <= 1'b1;
            end else begin
              state_q   <= S_LETTER;
              let_idx_q <= bus.let_start;
              let_rem_q <= bus.let_len;
              dig_val_q <= bus.dig_start;
              dig_rem_q <= bus.dig_len;
              char_q    <= let_char(bus.let_start);
              valid_q   <= 1'b1;
              busy_q    <= 1'b1;
            end
          end
        end
        S_LETTER: begin
          if (accept) begin
            if (let_rem_q == LW'(1)) begin
              let_rem_q <= '0;
              if (dig_rem_q != '0) begin
                state_q <= S_DIGIT;
                char_q  <= dig_char(dig_val_q);
              end else begin
                state_q <= S_DONE;
                char_q  <= IDLE_CHAR;
                valid_q <= 1'b0;
                done_q  <= 1'b1;
              end
            end else begin
              let_rem_q <= let_rem_q - LW'(1);
              let_idx_q <= let_idx_d;
              char_q    <= let_char(let_idx_d);
            end
          end
        end
        S_DIGIT: begin
          if (accept) begin
            if (dig_rem_q == LW'(1)) begin
              dig_rem_q <= '0;
              state_q   <= S_DONE;
              char_q    <= IDLE_CHAR;
              valid_q   <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              dig_rem_q <= dig_rem_q - LW'(1);
              dig_val_q <= dig_val_d;
              char_q    <= dig_char(dig_val_d);
            end
          end
        end
        S_DONE: begin
          // A start arriving here is deliberately dropped; IDLE is the only sampling state.
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          char_q  <= IDLE_CHAR;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.char       = char_q;
  assign bus.char_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_id_char_gen.sv
// Directed bench for id_char_gen: stimulus pushes hand-written expected events
// (characters, done=256, err=257) and a negedge monitor pops and compares them.
module tb_id_char_gen;
  localparam int EV_DONE = 256;
  localparam int EV_ERR  = 257;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  int   exp_q[$];
  logic hold_pending;
  logic [7:0] hold_char;

  id_char_if #(.LW(4)) bus ();

  id_char_gen #(.LW(4), .IDLE_CHAR(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_id(input string s, input bit with_done);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(int'(s[i]));
    if (with_done) exp_q.push_back(EV_DONE);
  endtask

  // Drives one start pulse, then scrambles the fields to show they were latched.
  task automatic do_start(input int ls, input int ll, input int ds, input int dl, input bit exp_busy);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.let_start = 5'(ls);
    bus.let_len   = 4'(ll);
    bus.dig_start = 4'(ds);
    bus.dig_len   = 4'(dl);
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.let_start = 5'd3;
    bus.let_len   = 4'd7;
    bus.dig_start = 4'd2;
    bus.dig_len   = 4'd1;
    check("busy_after_start", int'(bus.busy), int'(exp_busy));
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d events pending, required 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every accepted char, done pulse and err pulse must match the queue head.
  initial begin
    int ev;
    hold_pending = 1'b0;
    hold_char    = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          check("hold_valid", int'(bus.char_valid), 1);
          check("hold_char", int'(bus.char), int'(hold_char));
        end
        hold_pending = bus.char_valid && !bus.char_ready;
        hold_char    = bus.char;
        ev = -1;
        if (bus.char_valid && bus.char_ready) ev = int'(bus.char);
        else if (bus.done) ev = EV_DONE;
        else if (bus.err) ev = EV_ERR;
        if (!bus.char_valid) check("idle_char", int'(bus.char), 0);
        if (ev >= 0) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %0d, required none", ev);
          end else begin
            int req;
            req = exp_q.pop_front();
            if (ev != req) begin
              n_fail++;
              $display("FAIL event: got %0d, required %0d", ev, req);
            end else if (ev < 256) $display("[TB] char '%c' ok", ev[7:0]);
            else if (ev == EV_DONE) $display("[TB] done ok");
            else $display("[TB] err ok");
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests        = 0;
    n_fail         = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.let_start  = '0;
    bus.let_len    = '0;
    bus.dig_start  = '0;
    bus.dig_len    = '0;
    bus.char_ready = 1'b1;
    #3;
    check("rst_char", int'(bus.char), 0);
    check("rst_valid", int'(bus.char_valid), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_err", int'(bus.err), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Basic run, full-rate consumer.
    expect_id("ab12", 1'b1);
    do_start(0, 2, 1, 2, 1'b1);
    wait_drain("basic", 20);

    // Letter and digit wrap-around.
    expect_id("yzab890", 1'b1);
    do_start(24, 4, 8, 3, 1'b1);
    wait_drain("wrap", 30);

    // Consumer stalls for 3 clocks on the second character.
    expect_id("abc", 1'b1);
    do_start(0, 3, 0, 0, 1'b1);
    @(posedge clk); #1 bus.char_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 bus.char_ready = 1'b1;
    wait_drain("stall", 20);

    // Illegal requests: one err pulse each, busy stays low.
    exp_q.push_back(EV_ERR);
    do_start(0, 0, 0, 2, 1'b0);
    wait_drain("err_len0", 10);
    exp_q.push_back(EV_ERR);
    do_start(26, 2, 0, 2, 1'b0);
    wait_drain("err_let26", 10);
    exp_q.push_back(EV_ERR);
    do_start(0, 2, 10, 2, 1'b0);
    wait_drain("err_dig10", 10);

    // Letters only, then maximum-length identifier.
    expect_id("xyz", 1'b1);
    do_start(23, 3, 5, 0, 1'b1);
    wait_drain("letters_only", 20);
    expect_id("pqrstuvwxyzabcd789012345678901", 1'b1);
    do_start(15, 15, 7, 15, 1'b1);
    wait_drain("max_len", 60);

    // start while busy (even an illegal one) is ignored.
    expect_id("ab12", 1'b1);
    do_start(0, 2, 1, 2, 1'b1);
    bus.start   = 1'b1;
    bus.let_len = 4'd0;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_drain("start_busy", 20);
    repeat (5) @(posedge clk);

    // Asynchronous reset mid-cycle while in DIGIT aborts without done.
    expect_id("a01", 1'b0);
    do_start(0, 1, 0, 5, 1'b1);
    wait_drain("abort_pre", 20);
    #3 rst_n = 1'b0;
    #1;
    check("abort_char", int'(bus.char), 0);
    check("abort_valid", int'(bus.char_valid), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_abort_busy", int'(bus.busy), 0);
    check("post_abort_valid", int'(bus.char_valid), 0);

    // Generator still works after the abort.
    expect_id("c3", 1'b1);
    do_start(2, 1, 3, 1, 1'b1);
    wait_drain("after_abort", 20);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
